// File: rtl/cube_layer_driver.sv
// cube_layer_driver
// Scans an 8x8x8 LED cube one z-layer at a time. Each layer's 64 column bits
// are shifted MSB-first into external SIPO drivers, latched, and the matching
// layer transistor is enabled. A full frame snapshot is taken at frame start,
// so updates to Cells never tear the displayed image.
//
// Configuration macro: CUBE_DRIVER_GHOST_BLANK_EN
//   defined   - LayerSel is held at 0 for the whole LATCH state and switches
//               to the new layer on the first HOLD cycle (anti-ghosting).
//   undefined - LayerSel switches to the new layer on the first LATCH cycle.

module cube_layer_driver #(
  parameter int CLK_DIV    = 2,   // system cycles per SerClk half-period, >= 1
  parameter int LAYER_HOLD = 16   // cycles a latched layer is held, >= 1
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [511:0] Cells,
  input  logic         Blank,
  output logic         SerData,
  output logic         SerClk,
  output logic         SerLatch,
  output logic [7:0]   LayerSel,
  output logic         FrameDone
);

  localparam int SHIFT_LEN = 2 * CLK_DIV;
  localparam int CNT_MAX   = (SHIFT_LEN > LAYER_HOLD) ? SHIFT_LEN : LAYER_HOLD;
  localparam int CW        = $clog2(CNT_MAX + 1);

  // Phase-counter landmarks within each state.
  localparam logic [CW-1:0] SHIFT_LAST = CW'(SHIFT_LEN - 1);
  localparam logic [CW-1:0] HIGH_START = CW'(CLK_DIV);
  localparam logic [CW-1:0] LATCH_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(LAYER_HOLD - 1);

  typedef enum logic [1:0] {
    LOAD,
    SHIFT,
    LATCH,
    HOLD
  } state_t;

  state_t          state;
  logic [511:0]    frame_q;      // snapshot of Cells taken in LOAD
  logic [2:0]      z;            // current layer
  logic [5:0]      b;            // current column bit, counts 63 down to 0
  logic [CW-1:0]   cnt;          // cycle counter inside the current state
  logic [7:0]      layer_q;      // latched layer before the Blank mask
  logic            frame_seen;   // a LOAD has already happened since reset

  logic [7:0]      layer_onehot;
  logic [8:0]      bit_idx;

  assign layer_onehot = 8'(1) << z;
  assign bit_idx      = {z, b};

  // Frame snapshot: captured once per frame so the scan shows a consistent image.
  // NOTE: the 512-bit snapshot is deliberately not reset; it is always
  // overwritten in LOAD before any bit of it is shifted out, so a reset would
  // only add fan-out on the reset net.
  always_ff @(posedge Clk) begin
    if (Reset && state == LOAD) begin
      frame_q <= Cells;
    end
  end

  // Scan FSM: sequences shift, latch and hold for each layer and drives all outputs.
  // NOTE: every register here is assigned with <= so all updates use values
  // from before the edge; a blocking = would let later statements see the
  // new state within the same cycle and break the registered-output timing.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state      <= LOAD;
      z          <= '0;
      b          <= '0;
      cnt        <= '0;
      layer_q    <= '0;
      frame_seen <= 1'b0;
      SerData    <= 1'b0;
      SerClk     <= 1'b0;
      SerLatch   <= 1'b0;
      LayerSel   <= '0;
      FrameDone  <= 1'b0;
    end else begin
      FrameDone <= 1'b0;
      LayerSel  <= Blank ? 8'h00 : layer_q;

      unique case (state)
        LOAD: begin
          z          <= '0;
          b          <= 6'd63;
          cnt        <= '0;
          SerClk     <= 1'b0;
          SerLatch   <= 1'b0;
          FrameDone  <= frame_seen;
          frame_seen <= 1'b1;
          state      <= SHIFT;
        end

        SHIFT: begin
          SerLatch <= 1'b0;
          if (cnt == '0) begin
            SerData <= frame_q[bit_idx];
          end
          SerClk <= (cnt >= HIGH_START);
          if (cnt == SHIFT_LAST) begin
            cnt <= '0;
            if (b == 6'd0) begin
              state <= LATCH;
            end else begin
              b <= b - 6'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        LATCH: begin
          SerLatch <= 1'b1;
          SerClk   <= 1'b0;
          if (cnt == '0) begin
`ifdef CUBE_DRIVER_GHOST_BLANK_EN
            layer_q  <= '0;
            LayerSel <= '0;
`else
            layer_q  <= layer_onehot;
            LayerSel <= Blank ? 8'h00 : layer_onehot;
`endif
          end
          if (cnt == LATCH_LAST) begin
            cnt   <= '0;
            state <= HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        HOLD: begin
          SerLatch <= 1'b0;
`ifdef CUBE_DRIVER_GHOST_BLANK_EN
          if (cnt == '0) begin
            layer_q  <= layer_onehot;
            LayerSel <= Blank ? 8'h00 : layer_onehot;
          end
`endif
          if (cnt == HOLD_LAST) begin
            cnt <= '0;
            if (z == 3'd7) begin
              state <= LOAD;
            end else begin
              z     <= z + 3'd1;
              b     <= 6'd63;
              state <= SHIFT;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_cube_layer_driver.sv
// Testbench for cube_layer_driver: a timing table (with Blank / Cells stimulus
// fields) walked cycle by cycle, a serial-data scoreboard fed with expected
// frames when Cells is driven, and hand sequences for mid-scan reset and the
// latch/LayerSel relationship on a fast-parameter instance.

module tb_cube_layer_driver;

`ifdef CUBE_DRIVER_GHOST_BLANK_EN
  localparam bit GHOST = 1'b1;
`else
  localparam bit GHOST = 1'b0;
`endif

  logic         Clk = 1'b0;
  logic         Reset;
  logic [511:0] Cells;
  logic         Blank;
  logic         SerData, SerClk, SerLatch, FrameDone;
  logic [7:0]   LayerSel;

  logic         f_ser_data, f_ser_clk, f_ser_latch, f_frame_done;
  logic [7:0]   f_layer_sel;
  logic         f_blank = 1'b0;

  cube_layer_driver dut (
    .Clk(Clk), .Reset(Reset), .Cells(Cells), .Blank(Blank),
    .SerData(SerData), .SerClk(SerClk), .SerLatch(SerLatch),
    .LayerSel(LayerSel), .FrameDone(FrameDone)
  );

  cube_layer_driver #(.CLK_DIV(1), .LAYER_HOLD(4)) dut_fast (
    .Clk(Clk), .Reset(Reset), .Cells(Cells), .Blank(f_blank),
    .SerData(f_ser_data), .SerClk(f_ser_clk), .SerLatch(f_ser_latch),
    .LayerSel(f_layer_sel), .FrameDone(f_frame_done)
  );

  always #5 Clk = ~Clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // LayerSel expected during a LATCH cycle, depending on the build.
  function automatic logic [7:0] lat(input logic [7:0] s);
    return GHOST ? 8'h00 : s;
  endfunction

  // ---------------- scoreboard ----------------
  bit   exp_q[$];
  bit   sb_en    = 1'b0;
  logic prev_clk = 1'b0;
  bit   exp_bit;

  task automatic push_frame(input logic [511:0] c);
    for (int zz = 0; zz < 8; zz++)
      for (int bb = 63; bb >= 0; bb--)
        exp_q.push_back(c[zz*64 + bb]);
  endtask

  // Pops one expected bit per observed SerClk rise; also watches LayerSel.
  always @(negedge Clk) begin
    if (Reset !== 1'bx) begin
      check("layersel_onehot0", 32'($onehot0(LayerSel)), 32'd1);
      check("fast_layersel_onehot0", 32'($onehot0(f_layer_sel)), 32'd1);
    end
    if (sb_en && SerClk === 1'b1 && prev_clk === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_underflow @%0t: SerClk rose with no expected bit queued", $time);
      end else begin
        exp_bit = exp_q.pop_front();
        check("serdata", 32'(SerData), 32'(exp_bit));
      end
    end
    prev_clk <= SerClk;
  end

  // ---------------- vector tables ----------------
  typedef struct {
    int         k;          // sample index after the first LOAD edge
    logic       clk;
    logic       latch;
    logic [7:0] sel;
    logic       fd;
    logic       blank;      // Blank driven after this sample
    logic       push_ones;  // drive Cells to all ones and queue that frame
  } vec_t;

  typedef struct {
    int         k;
    logic       latch;
    logic [7:0] sel;
  } fvec_t;

  vec_t  tbl[$];
  fvec_t ftbl[$];

  task automatic add(input int k, input logic c, input logic l, input logic [7:0] s,
                     input logic f, input logic bl, input logic po);
    vec_t v;
    v.k = k; v.clk = c; v.latch = l; v.sel = s; v.fd = f; v.blank = bl; v.push_ones = po;
    tbl.push_back(v);
  endtask

  task automatic fadd(input int k, input logic l, input logic [7:0] s);
    fvec_t v;
    v.k = k; v.latch = l; v.sel = s;
    ftbl.push_back(v);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_serdata"},   32'(SerData),   32'd0);
    check({tag, "_serclk"},    32'(SerClk),    32'd0);
    check({tag, "_serlatch"},  32'(SerLatch),  32'd0);
    check({tag, "_layersel"},  32'(LayerSel),  32'd0);
    check({tag, "_framedone"}, 32'(FrameDone), 32'd0);
    check({tag, "_fast_layersel"}, 32'(f_layer_sel), 32'd0);
  endtask

  logic [511:0] pat_a;
  logic [511:0] pat_b;

  initial begin
    // Frame 1 (k=0..2192), frame 2 (2193..4385), frame 3 (4386..), defaults.
    //   k    clk lat sel    fd blank ones
    add(0,    0,  0,  8'h00, 0, 0, 0);
    add(1,    0,  0,  8'h00, 0, 0, 0);
    add(2,    0,  0,  8'h00, 0, 0, 0);
    add(3,    1,  0,  8'h00, 0, 0, 0);
    add(4,    1,  0,  8'h00, 0, 0, 0);
    add(5,    0,  0,  8'h00, 0, 0, 0);
    add(256,  1,  0,  8'h00, 0, 0, 0);
    add(257,  0,  1,  lat(8'h01), 0, 0, 0);
    add(258,  0,  1,  lat(8'h01), 0, 0, 0);
    add(259,  0,  0,  8'h01, 0, 0, 0);
    add(275,  0,  0,  8'h01, 0, 0, 0);
    add(277,  1,  0,  8'h01, 0, 0, 0);
    add(500,  0,  0,  8'h01, 0, 0, 1);
    add(531,  0,  1,  lat(8'h02), 0, 0, 0);
    add(2175, 0,  1,  lat(8'h80), 0, 0, 0);
    add(2192, 0,  0,  8'h80, 0, 0, 0);
    add(2193, 0,  0,  8'h80, 1, 0, 0);
    add(2194, 0,  0,  8'h80, 0, 0, 0);
    add(2450, 0,  1,  lat(8'h01), 0, 0, 0);
    add(2455, 0,  0,  8'h01, 0, 1, 1);
    add(2456, 0,  0,  8'h00, 0, 1, 0);
    add(2467, 0,  0,  8'h00, 0, 1, 0);
    add(2724, 0,  1,  8'h00, 0, 1, 0);
    add(2800, 1,  0,  8'h00, 0, 0, 0);
    add(2801, 1,  0,  8'h02, 0, 0, 0);
    add(4385, 0,  0,  8'h80, 0, 0, 0);
    add(4386, 0,  0,  8'h80, 1, 0, 0);
    add(4387, 0,  0,  8'h80, 0, 0, 0);
    add(5600, 0,  0,  8'h08, 0, 0, 0);
    add(5601, 1,  0,  8'h08, 0, 0, 0);

    // Fast instance (CLK_DIV=1, LAYER_HOLD=4): latch pulse vs LayerSel.
    fadd(128, 0, 8'h00);
    fadd(129, 1, lat(8'h01));
    fadd(130, 0, 8'h01);
    fadd(261, 0, 8'h01);
    fadd(262, 1, lat(8'h02));
    fadd(263, 0, 8'h02);

    pat_a = '0;
    pat_a[0]   = 1'b1;
    pat_a[511] = 1'b1;
    Cells = pat_a;
    Blank = 1'b0;
    Reset = 1'b0;

    // Reset held low for 3 cycles: everything reads 0.
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check_all_zero($sformatf("reset%0d", i));
    end

    push_frame(pat_a);
    sb_en = 1'b1;
    Reset = 1'b1;

    begin
      int ti = 0;
      int fi = 0;
      for (int k = 0; k <= 5601; k++) begin
        @(negedge Clk);
        if (ti < tbl.size() && tbl[ti].k == k) begin
          check($sformatf("serclk k=%0d", k),    32'(SerClk),    32'(tbl[ti].clk));
          check($sformatf("serlatch k=%0d", k),  32'(SerLatch),  32'(tbl[ti].latch));
          check($sformatf("layersel k=%0d", k),  32'(LayerSel),  32'(tbl[ti].sel));
          check($sformatf("framedone k=%0d", k), 32'(FrameDone), 32'(tbl[ti].fd));
          Blank = tbl[ti].blank;
          if (tbl[ti].push_ones) begin
            Cells = '1;
            push_frame(Cells);
          end
          ti++;
        end
        if (fi < ftbl.size() && ftbl[fi].k == k) begin
          check($sformatf("fast_serlatch k=%0d", k), 32'(f_ser_latch), 32'(ftbl[fi].latch));
          check($sformatf("fast_layersel k=%0d", k), 32'(f_layer_sel), 32'(ftbl[fi].sel));
          fi++;
        end
      end
    end

    // Reset while SerClk is high in layer 4 of frame 3.
    sb_en = 1'b0;
    Reset = 1'b0;
    @(negedge Clk);
    check_all_zero("midreset");
    exp_q.delete();
    for (int i = 0; i < 16; i++) pat_b[i*32 +: 32] = $urandom;
    Cells = pat_b;
    push_frame(pat_b);
    @(negedge Clk);
    check_all_zero("midreset_hold");
    sb_en = 1'b1;
    Reset = 1'b1;

    // Scan restarts at layer 0, b=63; first FrameDone only at the second LOAD.
    for (int k = 0; k <= 2195; k++) begin
      @(negedge Clk);
      case (k)
        0:    check("restart_serclk k=0", 32'(SerClk), 32'd0);
        3:    check("restart_serclk k=3", 32'(SerClk), 32'd1);
        257: begin
          check("restart_serlatch k=257", 32'(SerLatch), 32'd1);
          check("restart_layersel k=257", 32'(LayerSel), 32'(lat(8'h01)));
        end
        2192: check("restart_framedone k=2192", 32'(FrameDone), 32'd0);
        2193: check("restart_framedone k=2193", 32'(FrameDone), 32'd1);
        2194: sb_en = 1'b0;
        2195: check("sb_drained", 32'(exp_q.size()), 32'd0);
        default: ;
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
